// File: rtl/intra_tap_accum.sv
// intra_tap_accum: sums NTAPS product beats per lane across eight lanes, then
// rounds, shifts and clips each sum to an unsigned BITDEPTH-bit sample.
// The result is held under a valid/ready handshake until it is accepted.
module intra_tap_accum #(
  parameter int NTAPS    = 4,
  parameter int SHIFT    = 6,
  parameter int BITDEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sop,
  input  logic signed [15:0]  P1,
  input  logic signed [15:0]  P2,
  input  logic signed [15:0]  P3,
  input  logic signed [15:0]  P4,
  input  logic signed [15:0]  P5,
  input  logic signed [15:0]  P6,
  input  logic signed [15:0]  P7,
  input  logic signed [15:0]  P8,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITDEPTH-1:0] S1,
  output logic [BITDEPTH-1:0] S2,
  output logic [BITDEPTH-1:0] S3,
  output logic [BITDEPTH-1:0] S4,
  output logic [BITDEPTH-1:0] S5,
  output logic [BITDEPTH-1:0] S6,
  output logic [BITDEPTH-1:0] S7,
  output logic [BITDEPTH-1:0] S8,
  output logic                tap_err
);

  localparam int CW   = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int ACCW = 16 + $clog2(NTAPS) + 2;
  localparam logic signed [ACCW:0] RND_OFF = {{ACCW{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACCW:0] SAT_MAX = (ACCW+1)'((1 << BITDEPTH) - 1);

  // ACC  | collecting beats of a vector, in_ready=1
  // HOLD | final sums registered, result presented until accepted
  typedef enum logic {ACC, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [ACCW-1:0] acc_q [8];
  logic signed [ACCW-1:0] acc_d [8];
  logic                   tap_err_q, tap_err_d;

  logic signed [15:0]     p [8];
  logic                   beat, out_hs, tap0;
  logic [CW:0]            next_cnt;

  assign p[0] = P1;
  assign p[1] = P2;
  assign p[2] = P3;
  assign p[3] = P4;
  assign p[4] = P5;
  assign p[5] = P6;
  assign p[6] = P7;
  assign p[7] = P8;

  // In HOLD a new beat can only enter alongside the output handshake; reset
  // forces in_ready low so nothing is accepted while the block is cleared.
  assign in_ready  = rst_n & ((state_q == ACC) | out_ready);
  assign out_valid = (state_q == HOLD);
  assign tap_err   = tap_err_q;
  assign beat      = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  // Next-state: tap sequencing, accumulation and abort detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    tap_err_d = 1'b0;
    // cnt_q is always zero in HOLD, so a beat there starts a new vector.
    tap0      = in_sop || (cnt_q == '0);
    next_cnt  = tap0 ? (CW+1)'(1) : ({1'b0, cnt_q} + (CW+1)'(1));
    if (beat) begin
      for (int i = 0; i < 8; i++) begin
        if (tap0) acc_d[i] = ACCW'(p[i]);
        else      acc_d[i] = acc_q[i] + ACCW'(p[i]);
      end
      tap_err_d = in_sop && (cnt_q != '0);
      if (next_cnt == (CW+1)'(NTAPS)) begin
        state_d = HOLD;
        cnt_d   = '0;
      end else begin
        state_d = ACC;
        cnt_d   = next_cnt[CW-1:0];
      end
    end else if (out_hs) begin
      state_d = ACC;
      cnt_d   = '0;
    end
  end

  // State, counter, accumulators and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      cnt_q     <= '0;
      tap_err_q <= 1'b0;
      for (int i = 0; i < 8; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tap_err_q <= tap_err_d;
      for (int i = 0; i < 8; i++) acc_q[i] <= acc_d[i];
    end
  end

  // Round-half-up, floor shift and clip per lane; accumulators only change
  // on an accepted beat, so the samples stay stable while HOLD waits.
  for (genvar g = 0; g < 8; g++) begin : g_lane
    logic signed [ACCW:0]   rnd;
    logic signed [ACCW:0]   shf;
    logic [BITDEPTH-1:0]    lane_s;
    assign rnd    = {acc_q[g][ACCW-1], acc_q[g]} + RND_OFF;
    assign shf    = rnd >>> SHIFT;
    assign lane_s = (shf < 0)       ? '0 :
                    (shf > SAT_MAX) ? SAT_MAX[BITDEPTH-1:0] :
                                      shf[BITDEPTH-1:0];
  end

  assign S1 = g_lane[0].lane_s;
  assign S2 = g_lane[1].lane_s;
  assign S3 = g_lane[2].lane_s;
  assign S4 = g_lane[3].lane_s;
  assign S5 = g_lane[4].lane_s;
  assign S6 = g_lane[5].lane_s;
  assign S7 = g_lane[6].lane_s;
  assign S8 = g_lane[7].lane_s;

endmodule

// File: tb/tb_intra_tap_accum.sv
// Directed bench for intra_tap_accum at default parameters.
module tb_intra_tap_accum;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               in_sop;
  logic signed [15:0] p [8];
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         s [8];
  logic               tap_err;

  int checks = 0;
  int errors = 0;

  int basic_p [8] = '{-30, 80, 360, 240, 340, 230, -30, 70};
  // (4*Pi + 32) >>> 6, clipped to 0..255
  int basic_s [8] = '{0, 5, 23, 15, 21, 14, 0, 4};

  intra_tap_accum dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .P1(p[0]), .P2(p[1]), .P3(p[2]), .P4(p[3]),
    .P5(p[4]), .P6(p[5]), .P7(p[6]), .P8(p[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .S1(s[0]), .S2(s[1]), .S3(s[2]), .S4(s[3]),
    .S5(s[4]), .S6(s[5]), .S7(s[6]), .S8(s[7]),
    .tap_err(tap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int l = 0; l < 8; l++) p[l] = 16'(v);
  endtask

  function automatic int stream_val(int v, int t, int l);
    return ((v * 7 + l * 13 + t * 5) % 40) * 400 - 4000;
  endfunction

  function automatic int round_clip(int sum);
    int r;
    r = (sum + 32) >>> 6;
    if (r < 0) return 0;
    if (r > 255) return 255;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; out_ready = 1'b1;
    set_all(0);
    #3;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (tap_err !== 1'b0) begin errors++; $display("FAIL reset_tap_err: got %b expected 0", tap_err); end
    for (int l = 0; l < 8; l++) begin
      checks++;
      if (s[l] !== 8'd0) begin errors++; $display("FAIL reset_S%0d: got %0d expected 0", l+1, s[l]); end
    end
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int l = 0; l < 8; l++) p[l] = 16'(basic_p[l]);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sop = (k == 0);
      step();
      if (k < 3) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid beat %0d: got %b expected 0", k, out_valid); end
      end
    end
    in_valid = 1'b0; in_sop = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
    for (int l = 0; l < 8; l++) begin
      checks++;
      if (s[l] !== 8'(basic_s[l])) begin errors++; $display("FAIL basic_S%0d: got %0d expected %0d", l+1, s[l], basic_s[l]); end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      set_all(pass == 0 ? 16320 : -16320);
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_out_valid pass %0d: got %b expected 1", pass, out_valid); end
      for (int l = 0; l < 8; l++) begin
        checks++;
        if (s[l] !== (pass == 0 ? 8'd255 : 8'd0))
          begin errors++; $display("FAIL sat_S%0d pass %0d: got %0d expected %0d", l+1, pass, s[l], pass == 0 ? 255 : 0); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_all(100);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) step();
    // Offered beats during the stall must not be taken.
    set_all(1000);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cycle %0d: got %b expected 1", c, out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", c, in_ready); end
      checks++;
      if (s[0] !== 8'd6 || s[7] !== 8'd6) begin errors++; $display("FAIL bp_S_stable cycle %0d: got %0d/%0d expected 6", c, s[0], s[7]); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release: got %b expected 1", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_joint_handshake: got %b expected 0", out_valid); end
    for (int k = 0; k < 3; k++) step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b expected 1", out_valid); end
    for (int l = 0; l < 8; l++) begin
      checks++;
      if (s[l] !== 8'd63) begin errors++; $display("FAIL bp_next_S%0d: got %0d expected 63", l+1, s[l]); end
    end
    step();
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    set_all(5000);
    in_valid = 1'b1;
    in_sop = 1'b1;
    step();
    checks++;
    if (tap_err !== 1'b0) begin errors++; $display("FAIL abort_sop_at_zero: got %b expected 0", tap_err); end
    in_sop = 1'b0;
    step();
    set_all(200);
    in_sop = 1'b1;
    step();
    checks++;
    if (tap_err !== 1'b1) begin errors++; $display("FAIL abort_tap_err_pulse: got %b expected 1", tap_err); end
    in_sop = 1'b0;
    step();
    checks++;
    if (tap_err !== 1'b0) begin errors++; $display("FAIL abort_tap_err_single: got %b expected 0", tap_err); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_early_valid: got %b expected 0", out_valid); end
    step();
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_out_valid: got %b expected 1", out_valid); end
    for (int l = 0; l < 8; l++) begin
      checks++;
      if (s[l] !== 8'd13) begin errors++; $display("FAIL abort_S%0d: got %0d expected 13", l+1, s[l]); end
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    set_all(3000);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 0", in_ready); end
    step();
    rst_n = 1'b1;
    set_all(400);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k < 3) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early_valid beat %0d: got %b expected 0", k, out_valid); end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_out_valid_after: got %b expected 1", out_valid); end
    for (int l = 0; l < 8; l++) begin
      checks++;
      if (s[l] !== 8'd25) begin errors++; $display("FAIL rstmid_S%0d: got %0d expected 25", l+1, s[l]); end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int pulses;
    int sum;
    int exp_s;
    pulses = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      for (int l = 0; l < 8; l++) p[l] = 16'(stream_val(k / 4, k % 4, l));
      in_sop = ((k % 4) == 0);
      step();
      checks++;
      if (out_valid !== ((k % 4) == 3)) begin errors++; $display("FAIL stream_valid beat %0d: got %b expected %b", k, out_valid, (k % 4) == 3); end
      if (out_valid === 1'b1) pulses++;
      if ((k % 4) == 3) begin
        for (int l = 0; l < 8; l++) begin
          sum = 0;
          for (int t = 0; t < 4; t++) sum += stream_val(k / 4, t, l);
          exp_s = round_clip(sum);
          checks++;
          if (s[l] !== 8'(exp_s)) begin errors++; $display("FAIL stream_S%0d vec %0d: got %0d expected %0d", l+1, k / 4, s[l], exp_s); end
        end
      end
    end
    in_valid = 1'b0; in_sop = 1'b0;
    step();
    checks++;
    if (pulses !== 8) begin errors++; $display("FAIL stream_pulse_count: got %0d expected 8", pulses); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_tail_valid: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
